pipelined_adder: RTL

Parametrised, pipelined WIDTH-bit add/subtract unit; the registered, streaming successor to the team's fixed-width ripple adder. The operand is split into STAGES equal chunks, and each pipeline stage ripples one chunk through a `full_adder` chain. The carry is registered between stages. Upstream and downstream use a valid/ready handshake. The block sits in datapaths that need wide adds at full clock rate, with back-pressure.

---
 rtl/adder_pkg.sv | 16 +
 rtl/adder_chunk.sv | 33 +++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_adder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder family: operation encodings and
// chunk-size helpers used when elaborating the per-stage ripple slices.
package adder_pkg;

  localparam logic ADDER_OP_ADD = 1'b0;
  localparam logic ADDER_OP_SUB = 1'b1;

  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

  function automatic bit chunk_fits(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Purely combinational CHUNK-bit ripple-carry slice built from full_adder cells;
// one instance per pipeline stage of pipelined_adder.
module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // Per-bit carry nets live in the generate scope so the chain is not one looped vector.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = cin;
    end else begin : g_chain
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .s    (s[i]),
      .cout (co)
    );
  end

  assign cout = g_bit[CHUNK-1].co;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the ripple cell used by adder_chunk.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready handshake; one CHUNK rippled per stage.
// Defining PIPELINED_ADDER_OVERFLOW_EN adds a registered signed-overflow output.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!chunk_fits(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  b_in;
  logic              c_in;

  // Subtraction runs as a + ~b + !cin; both inversions happen before stage 0 captures.
  assign b_in = (sub == ADDER_OP_SUB) ? ~b : b;
  assign c_in = (sub == ADDER_OP_SUB) ? ~cin : cin;

  // The ready chain (!valid[k] || ready[k+1]) is unrolled: stage k may advance when
  // out_ready is high or any stage from k to the output holds a bubble.
  assign in_ready = out_ready || !(&valid_q);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] s_prev;
    logic [WIDTH-1:0] s_next;
    logic             c_prev;
    logic             v_prev;
    logic             load;
    logic             chunk_c;
    logic [CHUNK-1:0] chunk_s;

    if (k == 0) begin : g_head
      assign op_a   = a;
      assign op_b   = b_in;
      assign c_prev = c_in;
      assign v_prev = in_valid;
      assign s_prev = '0;
    end else begin : g_tail
      assign op_a   = a_q[k-1];
      assign op_b   = b_q[k-1];
      assign c_prev = c_q[k-1];
      assign v_prev = valid_q[k-1];
      assign s_prev = s_q[k-1];
    end

    assign load = out_ready || !(&valid_q[STAGES-1:k]);

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (op_a[k*CHUNK +: CHUNK]),
      .b    (op_b[k*CHUNK +: CHUNK]),
      .cin  (c_prev),
      .s    (chunk_s),
      .cout (chunk_c)
    );

    always_comb begin
      s_next = s_prev;
      s_next[k*CHUNK +: CHUNK] = chunk_s;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        c_q[k]     <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        s_q[k]     <= '0;
      end else if (load) begin
        valid_q[k] <= v_prev;
        c_q[k]     <= chunk_c;
        a_q[k]     <= op_a;
        b_q[k]     <= op_b;
        s_q[k]     <= s_next;
      end
    end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    if (k == STAGES - 1) begin : g_ovf
      logic msb_cin;
      logic ovf_q;
      // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ cin.
      assign msb_cin = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ chunk_s[CHUNK-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= msb_cin ^ chunk_c;
        end
      end
      assign overflow = ovf_q;
    end
`endif
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry     = c_q[STAGES-1];

endmodule
